// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cooking sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    COOKING = 3'd2,
    PAUSED  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned QUICK_START_SEC = 30;

endpackage

// File: rtl/microwave_sec_prescaler.sv
// Seconds prescaler: modulus counter with enable and clear.
// 'wrap' flags the terminal count; 'tick' pulses when the counter wraps.
module sec_prescaler #(
  parameter int unsigned MODULUS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap,
  output logic tick
);

  localparam int unsigned CNT_W = (MODULUS > 2) ? $clog2(MODULUS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

  logic [CNT_W-1:0] cnt;

  assign wrap = (cnt == LAST);
  assign tick = en && wrap;

  // Clear wins over enable so a fresh cook always starts a full second.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_ctrl.sv
// Microwave cooking sequencer: countdown timer plus S/R drive of the magnetron latch.
// Optional feature macro: MICROWAVE_QUICK_START_EN (start in IDLE cooks 30 s, start while cooking adds 30 s).
module microwave_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned TIME_W        = 12,
  parameter int unsigned MAX_TIME      = 3599
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              door_closed,
  input  logic              start,
  input  logic              stop_clear,
  input  logic              time_load,
  input  logic [TIME_W-1:0] time_in,
  output logic              mag_set,
  output logic              mag_reset,
  output logic              heating,
  output logic [TIME_W-1:0] time_left,
  output logic              done,
  output state_t            state
);

  state_t            state_n;
  logic [TIME_W-1:0] time_n;
  logic              set_n;
  logic              reset_n;
  logic              done_n;
  logic              pre_clr;
  logic              pre_en;
  logic              wrap;
  logic              tick;
  logic              pause_req;
  logic              go;
  logic              last_sec;
  logic [TIME_W-1:0] loaded;

  function automatic logic [TIME_W-1:0] sat(input logic [TIME_W:0] v);
    return (v > (TIME_W+1)'(MAX_TIME)) ? TIME_W'(MAX_TIME) : v[TIME_W-1:0];
  endfunction

  assign pause_req = !door_closed || stop_clear;
  assign go        = start && door_closed && !stop_clear;
  assign last_sec  = wrap && (time_left == TIME_W'(1));
  assign loaded    = sat({1'b0, time_in});

  // The prescaler freezes on a pause, except when expiry lands in the same cycle.
  assign pre_en = (state == COOKING) && (!pause_req || last_sec);

  sec_prescaler #(
    .MODULUS (TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .wrap (wrap),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    time_n  = time_left;
    set_n   = 1'b0;
    reset_n = 1'b0;
    done_n  = 1'b0;
    pre_clr = 1'b0;
    case (state)
      IDLE, READY: begin
        if (time_load) begin
          time_n  = loaded;
          state_n = (loaded != '0) ? READY : IDLE;
        end else if (go && state == READY) begin
          state_n = COOKING;
          set_n   = 1'b1;
          pre_clr = 1'b1;
        end
`ifdef MICROWAVE_QUICK_START_EN
        else if (go) begin
          time_n  = TIME_W'(QUICK_START_SEC);
          state_n = COOKING;
          set_n   = 1'b1;
          pre_clr = 1'b1;
        end
`endif
      end
      COOKING: begin
        if (last_sec) begin
          state_n = DONE;
          time_n  = '0;
          reset_n = 1'b1;
          done_n  = 1'b1;
        end else if (pause_req) begin
          state_n = PAUSED;
          reset_n = 1'b1;
        end else begin
          if (tick) time_n = time_left - 1'b1;
`ifdef MICROWAVE_QUICK_START_EN
          if (start) time_n = sat({1'b0, time_n} + (TIME_W+1)'(QUICK_START_SEC));
`endif
        end
      end
      PAUSED: begin
        if (stop_clear) begin
          state_n = IDLE;
          time_n  = '0;
        end else if (go) begin
          state_n = COOKING;
          set_n   = 1'b1;
        end
      end
      DONE: begin
        if (pause_req) begin
          state_n = IDLE;
          time_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // mag_reset is forced high for the cycle after reset so the latch starts off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      time_left <= '0;
      mag_set   <= 1'b0;
      mag_reset <= 1'b1;
      heating   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      time_left <= time_n;
      mag_set   <= set_n;
      mag_reset <= reset_n;
      heating   <= (state_n == COOKING);
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl: vector table, corner sequences and random
// stimulus against a cycle-level reference model. Honours MICROWAVE_QUICK_START_EN.
module tb_microwave_ctrl;
  import microwave_pkg::*;

  localparam int T    = 4;
  localparam int TW   = 12;
  localparam int MAXT = 3599;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          door_closed = 1'b1;
  logic          start = 1'b0;
  logic          stop_clear = 1'b0;
  logic          time_load = 1'b0;
  logic [TW-1:0] time_in = '0;
  logic          mag_set, mag_reset, heating, done;
  logic [TW-1:0] time_left;
  state_t        state;

  microwave_ctrl #(
    .TICKS_PER_SEC (T),
    .TIME_W        (TW),
    .MAX_TIME      (MAXT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .door_closed (door_closed),
    .start       (start),
    .stop_clear  (stop_clear),
    .time_load   (time_load),
    .time_in     (time_in),
    .mag_set     (mag_set),
    .mag_reset   (mag_reset),
    .heating     (heating),
    .time_left   (time_left),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: elapsed cycles within the current second plus seconds left.
  state_t m_state = IDLE;
  int     m_time  = 0;
  int     m_sub   = 0;
  bit     m_set   = 0;
  bit     m_reset = 0;
  bit     m_done  = 0;

  logic [18:0] exp_q[$];

  function automatic int clamp(input int v);
    return (v > MAXT) ? MAXT : v;
  endfunction

  task automatic model_update(input bit r, d, s, sc, tl, input int ti);
    bit go;
    go = s && d && !sc;
    if (r) begin
      m_state = IDLE; m_time = 0; m_sub = 0;
      m_set = 0; m_reset = 1; m_done = 0;
      return;
    end
    m_set = 0; m_reset = 0; m_done = 0;
    case (m_state)
      IDLE, READY: begin
        if (tl) begin
          m_time  = clamp(ti);
          m_state = (m_time > 0) ? READY : IDLE;
        end else if (go && m_state == READY) begin
          m_state = COOKING; m_sub = 0; m_set = 1;
        end
`ifdef MICROWAVE_QUICK_START_EN
        else if (go) begin
          m_time = QUICK_START_SEC; m_state = COOKING; m_sub = 0; m_set = 1;
        end
`endif
      end
      COOKING: begin
        if (m_sub == T - 1 && m_time == 1) begin
          m_state = DONE; m_time = 0; m_sub = 0; m_reset = 1; m_done = 1;
        end else if (!d || sc) begin
          m_state = PAUSED; m_reset = 1;
        end else begin
          if (m_sub == T - 1) begin
            m_sub = 0; m_time = m_time - 1;
          end else begin
            m_sub = m_sub + 1;
          end
`ifdef MICROWAVE_QUICK_START_EN
          if (s) m_time = clamp(m_time + QUICK_START_SEC);
`endif
        end
      end
      PAUSED: begin
        if (sc) begin
          m_state = IDLE; m_time = 0;
        end else if (go) begin
          m_state = COOKING; m_set = 1;
        end
      end
      DONE: begin
        if (sc || !d) begin
          m_state = IDLE; m_time = 0;
        end
      end
      default: m_state = IDLE;
    endcase
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, and score the DUT outputs.
  task automatic step(input bit r, d, s, sc, tl, input int ti);
    logic [18:0] exp_w;
    logic [18:0] act_w;
    rst = r; door_closed = d; start = s; stop_clear = sc; time_load = tl;
    time_in = TW'(ti);
    @(posedge clk);
    model_update(r, d, s, sc, tl, ti);
    exp_q.push_back({m_state, TW'(m_time), (m_state == COOKING), m_set, m_reset, m_done});
    #1;
    act_w = {state, time_left, heating, mag_set, mag_reset, done};
    exp_w = exp_q.pop_front();
    checks++;
    if (act_w !== exp_w || (mag_set && mag_reset)) begin
      failures++;
      $display("FAIL model t=%0t got state=%0d time=%0d heat=%b set=%b rst=%b done=%b expected state=%0d time=%0d heat=%b set=%b rst=%b done=%b",
               $time, act_w[18:16], act_w[15:4], act_w[3], act_w[2], act_w[1], act_w[0],
               exp_w[18:16], exp_w[15:4], exp_w[3], exp_w[2], exp_w[1], exp_w[0]);
    end
  endtask

  typedef struct {
    bit     rst, door, start, stop, load;
    int     tin;
    int     wait_n;
    state_t st;
    int     tl;
    bit     set, mreset, dn;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int  n;
    bit  d;
    bit  hit;

    // rst door start stop load tin wait | state time set reset done
    vecs[0]  = '{1, 1, 0, 0, 0, 0,    0, IDLE,    0,    0, 1, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0,    0, IDLE,    0,    0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 3,    0, READY,   3,    0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 0,    0, COOKING, 3,    1, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 0,    2, COOKING, 3,    0, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 0,    0, COOKING, 2,    0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 0,    3, COOKING, 1,    0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0,    2, COOKING, 1,    0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 0,    0, DONE,    0,    0, 1, 1};
    vecs[9]  = '{0, 1, 0, 0, 0, 0,    0, DONE,    0,    0, 0, 0};
    vecs[10] = '{0, 1, 0, 1, 0, 0,    0, IDLE,    0,    0, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 1, 2,    0, READY,   2,    0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 0,    0, READY,   2,    0, 0, 0};
    vecs[13] = '{0, 1, 1, 1, 0, 0,    0, READY,   2,    0, 0, 0};
    vecs[14] = '{0, 1, 0, 0, 1, 4000, 0, READY,   3599, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 1, 0,    0, IDLE,    0,    0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].door, vecs[i].start, vecs[i].stop, vecs[i].load, vecs[i].tin);
      for (int w = 0; w < vecs[i].wait_n; w++) step(0, vecs[i].door, 0, 0, 0, 0);
      check($sformatf("vec%0d.state", i), int'(state), int'(vecs[i].st));
      check($sformatf("vec%0d.time_left", i), int'(time_left), vecs[i].tl);
      check($sformatf("vec%0d.mag_set", i), int'(mag_set), int'(vecs[i].set));
      check($sformatf("vec%0d.mag_reset", i), int'(mag_reset), int'(vecs[i].mreset));
      check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].dn));
      check($sformatf("vec%0d.heating", i), int'(heating), int'(vecs[i].st == COOKING));
    end

    // Pause on door open mid-second, then resume from the frozen prescaler.
    step(0, 1, 0, 0, 1, 5);
    step(0, 1, 1, 0, 0, 0);
    check("pause.start_set", int'(mag_set), 1);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("pause.state", int'(state), int'(PAUSED));
    check("pause.mag_reset", int'(mag_reset), 1);
    check("pause.time_left", int'(time_left), 4);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    check("pause.frozen_time", int'(time_left), 4);
    check("pause.frozen_reset", int'(mag_reset), 0);
    step(0, 1, 1, 0, 0, 0);
    check("resume.state", int'(state), int'(COOKING));
    check("resume.mag_set", int'(mag_set), 1);
    // Two cycles left of the frozen second, then three full seconds.
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      step(0, 1, 0, 0, 0, 0);
      n = c;
      if (done) break;
    end
    check("resume.expiry_cycles", n, 2 + 3 * T);
    check("resume.expiry_reset", int'(mag_reset), 1);
    step(0, 1, 0, 1, 0, 0);

    // Reset while cooking.
    step(0, 1, 0, 0, 1, 5);
    step(0, 1, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("rst_mid.mag_reset", int'(mag_reset), 1);
    check("rst_mid.time_left", int'(time_left), 0);
    check("rst_mid.state", int'(state), int'(IDLE));
    check("rst_mid.heating", int'(heating), 0);
    step(0, 1, 0, 0, 0, 0);
    check("rst_mid.reset_drop", int'(mag_reset), 0);

`ifdef MICROWAVE_QUICK_START_EN
    step(0, 1, 1, 0, 0, 0);
    check("quick.time_left", int'(time_left), 30);
    check("quick.mag_set", int'(mag_set), 1);
    check("quick.state", int'(state), int'(COOKING));
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      step(0, 1, 0, 0, 0, 0);
      if (time_left == TW'(10)) begin
        hit = 1;
        break;
      end
    end
    check("quick.reach_10", int'(hit), 1);
    step(0, 1, 1, 0, 0, 0);
    check("quick.add_30", int'(time_left), 40);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
`else
    step(0, 1, 1, 0, 0, 0);
    check("noquick.state", int'(state), int'(IDLE));
    check("noquick.time_left", int'(time_left), 0);
    check("noquick.mag_set", int'(mag_set), 0);
`endif

    // Randomised run against the model.
    d = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) d = !d;
      step($urandom_range(0, 499) == 0, d,
           $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 14) == 0,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
